// File: rtl/weight_tile_buffer.sv
// Ping-pong tile buffer: packs a scalar weight stream into ARRAY_DIM x ARRAY_DIM tiles and
// drains each full tile one row per handshake. Define WEIGHT_TILE_BUFFER_ZERO_PAD_EN to pad on flush.
module weight_tile_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_DIM  = 4,
  localparam int unsigned CNT_W     = $clog2(ARRAY_DIM * ARRAY_DIM + 1),
  localparam int unsigned ROW_W     = $clog2(ARRAY_DIM)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [DATA_WIDTH-1:0]         s_tdata,
  input  logic                          flush,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] row_data,
  output logic [ROW_W-1:0]              row_index,
  output logic                          row_last,
  output logic [CNT_W-1:0]              fill_level,
  output logic [15:0]                   tiles_done,
  output logic                          busy
);

  localparam int unsigned TileSize = ARRAY_DIM * ARRAY_DIM;
  localparam int unsigned IdxW     = $clog2(TileSize);

  logic [DATA_WIDTH-1:0] bank_q [2][TileSize];
  logic [DATA_WIDTH-1:0] bank_d [2][TileSize];
  logic [1:0]            bank_full_q, bank_full_d;
  logic                  fill_sel_q, fill_sel_d;
  logic                  drain_sel_q, drain_sel_d;
  logic [CNT_W-1:0]      fill_cnt_q, fill_cnt_d;
  logic [ROW_W-1:0]      drain_row_q, drain_row_d;
  logic [15:0]           tiles_done_q, tiles_done_d;

  logic                  s_acc;
  logic                  row_acc;
  logic [IdxW-1:0]       rd_idx;

  always_comb begin
    s_tready  = !reset && !flush && !bank_full_q[fill_sel_q];
    s_acc     = s_tvalid && s_tready;
    row_valid = bank_full_q[drain_sel_q];
    row_acc   = row_valid && row_ready;
    row_last  = row_valid && (drain_row_q == ROW_W'(ARRAY_DIM - 1));
    row_data  = '0;
    row_index = '0;
    rd_idx    = '0;
    // Zero the row bus whenever nothing is presented.
    if (row_valid) begin
      row_index = drain_row_q;
      for (int c = 0; c < int'(ARRAY_DIM); c++) begin
        rd_idx = IdxW'(int'(drain_row_q) * int'(ARRAY_DIM) + c);
        row_data[c*DATA_WIDTH +: DATA_WIDTH] = bank_q[drain_sel_q][rd_idx];
      end
    end
    fill_level = fill_cnt_q;
    tiles_done = tiles_done_q;
    busy       = (|bank_full_q) || (fill_cnt_q != '0);
  end

  always_comb begin
    bank_d       = bank_q;
    bank_full_d  = bank_full_q;
    fill_sel_d   = fill_sel_q;
    drain_sel_d  = drain_sel_q;
    fill_cnt_d   = fill_cnt_q;
    drain_row_d  = drain_row_q;
    tiles_done_d = tiles_done_q;

    if (s_acc) begin
      bank_d[fill_sel_q][IdxW'(fill_cnt_q)] = s_tdata;
      if (fill_cnt_q == CNT_W'(TileSize - 1)) begin
        bank_full_d[fill_sel_q] = 1'b1;
        fill_sel_d              = ~fill_sel_q;
        fill_cnt_d              = '0;
      end else begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
    end

    // s_tready is low during flush, so this never races with an accept.
    if (flush && (fill_cnt_q != '0)) begin
`ifdef WEIGHT_TILE_BUFFER_ZERO_PAD_EN
      for (int k = 0; k < int'(TileSize); k++) begin
        if (CNT_W'(k) >= fill_cnt_q) begin
          bank_d[fill_sel_q][k] = '0;
        end
      end
      bank_full_d[fill_sel_q] = 1'b1;
      fill_sel_d              = ~fill_sel_q;
`endif
      fill_cnt_d = '0;
    end

    if (row_acc) begin
      if (row_last) begin
        bank_full_d[drain_sel_q] = 1'b0;
        drain_sel_d              = ~drain_sel_q;
        drain_row_d              = '0;
        tiles_done_d             = tiles_done_q + 16'd1;
      end else begin
        drain_row_d = drain_row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_full_q  <= '0;
      fill_sel_q   <= 1'b0;
      drain_sel_q  <= 1'b0;
      fill_cnt_q   <= '0;
      drain_row_q  <= '0;
      tiles_done_q <= '0;
    end else begin
      bank_full_q  <= bank_full_d;
      fill_sel_q   <= fill_sel_d;
      drain_sel_q  <= drain_sel_d;
      fill_cnt_q   <= fill_cnt_d;
      drain_row_q  <= drain_row_d;
      tiles_done_q <= tiles_done_d;
    end
  end

  // Storage carries no reset; the full flags gate every read.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

endmodule

// File: doc/weight_tile_buffer.md
Name: weight_tile_buffer

Overview:
Ping-pong tile buffer directly downstream of the weight loader's AXI-Stream output. It packs the scalar weight stream, row-major, into ARRAY_DIM x ARRAY_DIM tiles across two banks. It then presents each complete tile to the systolic PE array one row per handshake. While one bank drains into the array, the other bank fills, so weight streaming overlaps array loading.

Parameters:
DATA_WIDTH, 8, bits per weight
ARRAY_DIM, 4, PE array edge; tile = ARRAY_DIM*ARRAY_DIM weights; legal range 2..16
CNT_W, $clog2(ARRAY_DIM*ARRAY_DIM+1), derived (localparam), width of fill_level

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
s_tvalid  in  1  weight stream valid (from loader weight_tvalid)
s_tready  out  1  weight stream ready (to loader weight_tready)
s_tdata  in  DATA_WIDTH  weight value
flush  in  1  sync pulse; abandons (or pads, see option) the partially filled tile
row_valid  out  1  a row of the current drain tile is presented
row_ready  in  1  PE array accepts the row
row_data  out  ARRAY_DIM*DATA_WIDTH  row weights; column c at [c*DATA_WIDTH +: DATA_WIDTH]
row_index  out  $clog2(ARRAY_DIM)  row number within tile, 0 first
row_last  out  1  high with final row of tile
fill_level  out  CNT_W  weights held in the current fill bank
tiles_done  out  16  count of fully drained tiles
busy  out  1  any bank full or fill_level != 0

Behaviour:
- State per bank: bank_full[1:0]. Plus fill_sel, drain_sel, fill_cnt, drain_row.
- Reset (async): bank_full=0, fill_sel=drain_sel=0, fill_cnt=0, drain_row=0, tiles_done=0.
- Outputs during reset: s_tready=0, row_valid=0, row_data=0, row_index=0, row_last=0, fill_level=0, busy=0.
- Bank storage is not reset.
- s_tready = !reset && !flush && !bank_full[fill_sel]. Combinational from registers, with no dependence on s_tvalid.
- Accept when s_tvalid && s_tready:
  - Write bank[fill_sel][fill_cnt] <= s_tdata; element k maps to row k/ARRAY_DIM, col k%ARRAY_DIM.
  - fill_cnt++.
  - If fill_cnt == ARRAY_DIM^2-1: set bank_full[fill_sel], toggle fill_sel, clear fill_cnt.
- Drain side:
  - row_valid = bank_full[drain_sel].
  - row_data/row_index = row drain_row of bank drain_sel. row_data and row_index are forced to 0 when row_valid=0.
  - row_last = row_valid && drain_row == ARRAY_DIM-1.
  - row_valid/row_data must hold stable until accepted.
- Row accept when row_valid && row_ready:
  - drain_row++.
  - If row_last: clear bank_full[drain_sel], toggle drain_sel, drain_row=0, tiles_done++ (wraps 65535->0).
- Latency: row 0 of a tile is valid the cycle after its last weight is accepted, when that bank is next to drain.
- Throughput:
  - Input 1 weight/cycle while the fill bank is not full.
  - Output 1 row/cycle while a bank is full.
- Both banks full: s_tready=0 until a drain completes. Ready rises the cycle after the row_last handshake, giving a 1-cycle bubble.
- Simultaneous fill completion and drain completion on different banks: both take effect; the counters are independent.
- A bank is never written while full, and never drained while not full.
- flush (no option):
  - fill_cnt <= 0; partial-tile weights discarded.
  - Full banks, drain_sel and drain_row are untouched.
  - No input accepted in the flush cycle.
  - flush with fill_cnt==0 has no effect.
- Reset mid-tile: all progress lost, with no spurious row_valid after release.
- fill_level = fill_cnt.
- busy = |bank_full || fill_cnt != 0.

Optional Feature:
WEIGHT_TILE_BUFFER_ZERO_PAD_EN
- Defined: flush with fill_cnt != 0 zero-fills entries fill_cnt..ARRAY_DIM^2-1 of the fill bank in the same cycle. It also sets that bank's full flag, toggles fill_sel and clears fill_cnt, so the partial tile drains as a zero-padded tile. flush with fill_cnt==0 has no effect.
- Undefined: flush discards the partial tile as described in Behaviour; no padding logic is synthesized.

Test Plan:
(All cases use DATA_WIDTH=8, ARRAY_DIM=4.)
- Reset/idle: reset then idle → s_tready=1, row_valid=0, busy=0, tiles_done=0.
- Single tile: stream 0x01..0x10 with row_ready=1 →
  - row_valid rises the cycle after 0x10 is accepted.
  - Rows are 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; row_last on row 3; tiles_done=1.
- Backpressure/ping-pong: row_ready=0, stream 40 weights →
  - Accepts exactly 32; s_tready=0 after 32.
  - Raise row_ready: tile A's 4 rows, then tile B's, then the 8 remaining weights are accepted.
- Row hold: row_ready toggled randomly → row_data/row_index stable while row_valid && !row_ready; no rows lost or duplicated over 10 tiles.
- Flush: stream 5 weights, pulse flush, stream 16 weights →
  - Without the macro: tile is 16 new weights only, tiles_done=1.
  - With WEIGHT_TILE_BUFFER_ZERO_PAD_EN: first tile is the 5 weights plus 11 zeros, then a second tile; tiles_done=2.
- Async reset mid-drain: assert reset after row 1 of a tile → row_valid=0 immediately, tiles_done=0; new tile after release drains normally.
